// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, one-byte holding
// register with framing-error pulse and sticky overrun.
module uart_rx #(
  parameter int D = 234,
  parameter int L = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rxd,
  input  logic         i_re,
  output logic [L-1:0] o_data,
  output logic         o_valid,
  output logic         o_ferr,
  output logic         o_ovr,
  output logic         o_busy
);
  localparam int CW = $clog2(D);
  localparam int IW = $clog2(L + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CW-1:0] HALF_M1  = CW'(D / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(D - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);

  logic          s1_q, rxs_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [L-1:0]  sh_q, sh_d;
  logic          arm_q, arm_d;
  logic [L-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          got_byte, got_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q  <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      s1_q  <= i_rxd;
      rxs_q <= s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    arm_d    = arm_q;
    got_byte = 1'b0;
    got_err  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A start is only accepted after the line has been seen high, so a
        // held-low break or a line low out of reset never retriggers.
        if (rxs_q) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          arm_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[L-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == BIT_M1) begin
          cnt_d    = '0;
          state_d  = IDLE;
          got_byte = rxs_q;
          got_err  = ~rxs_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output side never back-pressures the receiver; a read coinciding with a
  // new byte counts as consumed, so no overrun is flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = got_err;
    if (got_byte) begin
      data_d  = sh_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~i_re;
    end else if (i_re && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      arm_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ferr  = ferr_q;
  assign o_ovr   = ovr_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are built bit by bit from the serial format and
// outputs are predicted from frame timing arithmetic and a holding-register model.
module tb_uart_rx;
  localparam int D   = 234;
  localparam int L   = 8;
  // Edges from the i_rxd falling edge to the edge that loads the byte.
  localparam int LAT = 2 + D / 2 + (L + 1) * D + 1;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_rxd = 1'b1;
  logic         i_re  = 1'b0;
  logic [L-1:0] o_data;
  logic         o_valid, o_ferr, o_ovr, o_busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int re_cyc = -10;
  int valid_rise_cyc = -1, valid_rise_cnt = 0;
  int ferr_cnt = 0, ferr_cyc = -1;
  int busy_rise_cyc = -1, busy_fall_cyc = -1;
  logic pv = 1'b0, pb = 1'b0;

  uart_rx #(.D(D), .L(L)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rxd  (i_rxd),
    .i_re   (i_re),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_ferr (o_ferr),
    .o_ovr  (o_ovr),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // i_re is high for the one cycle following edge number re_cyc.
  always @(posedge i_clk) begin
    #1;
    i_re = (cyc == re_cyc);
  end

  always @(negedge i_clk) begin
    if (o_valid && !pv) begin
      valid_rise_cyc = cyc;
      valid_rise_cnt++;
    end
    if (o_ferr) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (o_busy && !pb) busy_rise_cyc = cyc;
    if (!o_busy && pb) busy_fall_cyc = cyc;
    pv = o_valid;
    pb = o_busy;
  end

  task automatic drive_bit(input logic b, input int n);
    @(posedge i_clk);
    #1;
    i_rxd = b;
    repeat (n - 1) @(posedge i_clk);
  endtask

  task automatic send_frame(input logic [L-1:0] data, input logic stop,
                            input bit re_land, output int fall);
    @(posedge i_clk);
    #1;
    i_rxd = 1'b0;
    fall = cyc;
    if (re_land) re_cyc = fall + LAT - 1;
    repeat (D - 1) @(posedge i_clk);
    for (int k = 0; k < L; k++) drive_bit(data[k], D);
    drive_bit(stop, D);
  endtask

  task automatic read_pulse();
    @(posedge i_clk);
    #2;
    re_cyc = cyc + 1;
    repeat (3) @(posedge i_clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #2;
    n_chk++;
    if ({o_data, o_valid, o_ferr, o_ovr, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
               o_data, o_valid, o_ferr, o_ovr, o_busy);
    end
    i_rst = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    n_chk++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b v=%b want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_basic();
    int f;
    valid_rise_cyc = -1;
    send_frame(8'h01, 1'b1, 1'b0, f);
    drive_bit(1'b1, 5);
    #2;
    n_chk++;
    if (valid_rise_cyc - f !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", valid_rise_cyc - f, LAT);
    end
    n_chk++;
    if (o_data !== 8'h01 || o_valid !== 1'b1 || o_ovr !== 1'b0 || ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL basic_out: got data=%h v=%b ov=%b ferrs=%0d want 01 1 0 0",
               o_data, o_valid, o_ovr, ferr_cnt);
    end
    read_pulse();
    n_chk++;
    if (o_valid !== 1'b0 || o_data !== 8'h01) begin
      n_fail++;
      $display("FAIL basic_read: got v=%b data=%h want 0 01", o_valid, o_data);
    end
  endtask

  task automatic test_ferr_break();
    int f, fc, vc;
    fc = ferr_cnt;
    vc = valid_rise_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, f);
    // Line stays low as a break for two more bit times.
    repeat (2 * D) @(posedge i_clk);
    #2;
    n_chk++;
    if (ferr_cnt - fc !== 1 || ferr_cyc - f !== LAT) begin
      n_fail++;
      $display("FAIL ferr_pulse: got count=%0d at=%0d want 1 at %0d",
               ferr_cnt - fc, ferr_cyc - f, LAT);
    end
    n_chk++;
    if (o_valid !== 1'b0 || valid_rise_cnt !== vc || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_break: got v=%b rises=%0d busy=%b want 0 0 0",
               o_valid, valid_rise_cnt - vc, o_busy);
    end
    drive_bit(1'b1, D);
    send_frame(8'h3C, 1'b1, 1'b0, f);
    drive_bit(1'b1, 5);
    #2;
    n_chk++;
    if (o_data !== 8'h3C || o_valid !== 1'b1 || ferr_cnt - fc !== 1) begin
      n_fail++;
      $display("FAIL ferr_next: got data=%h v=%b ferrs=%0d want 3c 1 1",
               o_data, o_valid, ferr_cnt - fc);
    end
    read_pulse();
  endtask

  task automatic test_glitch();
    int f, fc, vc;
    fc = ferr_cnt;
    vc = valid_rise_cnt;
    @(posedge i_clk);
    #1;
    i_rxd = 1'b0;
    f = cyc;
    repeat (50) @(posedge i_clk);
    #1;
    i_rxd = 1'b1;
    repeat (200) @(posedge i_clk);
    #2;
    n_chk++;
    if (busy_rise_cyc - f !== 3 || busy_fall_cyc - f !== 2 + D / 2 + 1) begin
      n_fail++;
      $display("FAIL glitch_busy: got rise=%0d fall=%0d want 3 %0d",
               busy_rise_cyc - f, busy_fall_cyc - f, 2 + D / 2 + 1);
    end
    n_chk++;
    if (valid_rise_cnt !== vc || ferr_cnt !== fc || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_out: got rises=%0d ferrs=%0d v=%b want 0 0 0",
               valid_rise_cnt - vc, ferr_cnt - fc, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    int f;
    send_frame(8'h55, 1'b1, 1'b0, f);
    send_frame(8'hAA, 1'b1, 1'b0, f);
    drive_bit(1'b1, 5);
    #2;
    n_chk++;
    if (o_data !== 8'hAA || o_valid !== 1'b1 || o_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ovr: got data=%h v=%b ov=%b want aa 1 1", o_data, o_valid, o_ovr);
    end
    read_pulse();
    n_chk++;
    if (o_valid !== 1'b0 || o_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read: got v=%b ov=%b want 0 0", o_valid, o_ovr);
    end
  endtask

  task automatic test_read_on_land();
    int f;
    send_frame(8'h55, 1'b1, 1'b0, f);
    drive_bit(1'b1, 10);
    send_frame(8'hAA, 1'b1, 1'b1, f);
    drive_bit(1'b1, 5);
    #2;
    n_chk++;
    if (o_data !== 8'hAA || o_valid !== 1'b1 || o_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL land_read: got data=%h v=%b ov=%b want aa 1 0", o_data, o_valid, o_ovr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pat;
    int f, fc, vc;
    pat = 8'h96;
    drive_bit(1'b0, D);
    for (int k = 0; k < 4; k++) drive_bit(pat[k], D);
    drive_bit(pat[4], D / 2);
    #2;
    n_chk++;
    if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got busy=%b v=%b want 1 1", o_busy, o_valid);
    end
    #1;
    i_rst = 1'b1;
    #1;
    n_chk++;
    if ({o_data, o_valid, o_ferr, o_ovr, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
               o_data, o_valid, o_ferr, o_ovr, o_busy);
    end
    fc = ferr_cnt;
    vc = valid_rise_cnt;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_rxd = 1'b1;
    repeat (D) @(posedge i_clk);
    send_frame(8'hC3, 1'b1, 1'b0, f);
    drive_bit(1'b1, 5);
    #2;
    n_chk++;
    if (o_data !== 8'hC3 || o_valid !== 1'b1 || valid_rise_cnt - vc !== 1 || ferr_cnt !== fc) begin
      n_fail++;
      $display("FAIL mid_after: got data=%h v=%b rises=%0d ferrs=%0d want c3 1 1 0",
               o_data, o_valid, valid_rise_cnt - vc, ferr_cnt - fc);
    end
  endtask

  task automatic test_random();
    logic [L-1:0] b, exp_data;
    logic st, exp_valid, exp_ovr;
    int f, fc;
    read_pulse();
    exp_data = 8'hC3;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = L'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      fc = ferr_cnt;
      send_frame(b, st, 1'b0, f);
      drive_bit(1'b1, int'($urandom_range(3, 30)));
      #2;
      if (st) begin
        if (exp_valid) exp_ovr = 1'b1;
        exp_data = b;
        exp_valid = 1'b1;
      end
      n_chk++;
      if (ferr_cnt - fc !== (st ? 0 : 1)) begin
        n_fail++;
        $display("FAIL rnd_ferr[%0d]: got %0d want %0d", i, ferr_cnt - fc, st ? 0 : 1);
      end
      n_chk++;
      if (o_data !== exp_data || o_valid !== exp_valid || o_ovr !== exp_ovr) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: got data=%h v=%b ov=%b want %h %b %b",
                 i, o_data, o_valid, o_ovr, exp_data, exp_valid, exp_ovr);
      end
      if ($urandom_range(0, 1) == 1) begin
        read_pulse();
        if (exp_valid) begin
          exp_valid = 1'b0;
          exp_ovr = 1'b0;
        end
        n_chk++;
        if (o_valid !== exp_valid || o_ovr !== exp_ovr || o_data !== exp_data) begin
          n_fail++;
          $display("FAIL rnd_read[%0d]: got v=%b ov=%b data=%h want %b %b %h",
                   i, o_valid, o_ovr, o_data, exp_valid, exp_ovr, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ferr_break();
    test_glitch();
    test_back_to_back();
    test_read_on_land();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
